// File: rtl/axi_scratch_responder.sv
// axi_scratch_responder
//   AXI4 subordinate that backs a small word-addressed register array used as a
//   host<->RoT scratch/mailbox window. Serves one transaction at a time. When AW
//   and AR arrive together, the side that currently holds priority is granted, and
//   priority flips after each accepted AW or AR. FIXED and INCR bursts are
//   supported. A WRAP burst, an oversized beat or an atomic write is answered with
//   SLVERR on every beat. Any beat that falls outside the window gets DECERR.
//
//   Ports
//     clk_i      clock
//     rst_i      asynchronous, active-high reset (also clears the array)
//     axi_req_i  AXI request: AW/W/AR payloads and valids, b_ready, r_ready
//     axi_rsp_o  AXI response: aw/w/ar_ready, B/R payloads and valids

package axi_scratch_pkg;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [0:0]  user;
    } aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [0:0]  user;
    } w_chan_t;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } ar_chan_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;

endpackage

module axi_scratch_responder #(
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter logic [AXI_ADDR_WIDTH-1:0] BaseAddr = '0,
    parameter int unsigned NumWords       = 16,
    parameter type axi_req_t = axi_scratch_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_scratch_pkg::axi_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_rsp_o
);

    localparam int unsigned BYTES_PER_WORD = AXI_DATA_WIDTH / 8;
    localparam int unsigned OFF_W          = $clog2(BYTES_PER_WORD);
    localparam int unsigned IDX_W          = $clog2(NumWords);
    localparam logic [AXI_ADDR_WIDTH-1:0] WIN_BYTES =
        AXI_ADDR_WIDTH'(NumWords * BYTES_PER_WORD);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        WRESP,
        RDATA
    } state_e;

    state_e state_q, state_d;

    logic                      prio_w_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic [7:0]                cnt_q;
    logic                      txn_err_q;
    logic [1:0]                err_q;

    logic [AXI_DATA_WIDTH-1:0] mem_q [NumWords];

    logic                      grant_w;
    logic                      grant_r;
    logic                      aw_illegal;
    logic                      ar_illegal;
    logic [AXI_ADDR_WIDTH-1:0] beat_off;
    logic                      beat_in_range;
    logic                      beat_ok;
    logic [IDX_W-1:0]          beat_idx;
    logic [1:0]                beat_resp;
    logic [AXI_ADDR_WIDTH-1:0] next_addr;
    logic                      read_last;
    logic [AXI_USER_WIDTH-1:0] user_zero;

    logic unused_req;
    assign unused_req = ^{axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot,
                          axi_req_i.aw.qos, axi_req_i.aw.region, axi_req_i.aw.user,
                          axi_req_i.w.user, axi_req_i.ar.lock, axi_req_i.ar.cache,
                          axi_req_i.ar.prot, axi_req_i.ar.qos, axi_req_i.ar.region,
                          axi_req_i.ar.user};

    assign user_zero = '0;

    assign aw_illegal = (axi_req_i.aw.burst == BURST_WRAP) ||
                        (32'(axi_req_i.aw.size) > OFF_W) ||
                        (axi_req_i.aw.atop != '0);
    assign ar_illegal = (axi_req_i.ar.burst == BURST_WRAP) ||
                        (32'(axi_req_i.ar.size) > OFF_W);

    // An address below the base wraps to a huge offset, so one unsigned compare
    // covers both ends of the window.
    assign beat_off      = addr_q - BaseAddr;
    assign beat_in_range = beat_off < WIN_BYTES;
    assign beat_idx      = IDX_W'(beat_off >> OFF_W);
    assign beat_ok       = !txn_err_q && beat_in_range;
    assign beat_resp     = txn_err_q     ? RESP_SLVERR :
                           beat_in_range ? RESP_OKAY   : RESP_DECERR;
    assign next_addr     = (burst_q == BURST_FIXED) ? addr_q
                                                    : addr_q + (AXI_ADDR_WIDTH'(1) << size_q);
    assign read_last     = (cnt_q == len_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grants are gated by reset so no ready can appear while rst_i is held.
    always_comb begin
        state_d   = state_q;
        axi_rsp_o = '0;
        grant_w   = 1'b0;
        grant_r   = 1'b0;
        case (state_q)
            IDLE: begin
                grant_w = !rst_i && axi_req_i.aw_valid && (!axi_req_i.ar_valid || prio_w_q);
                grant_r = !rst_i && axi_req_i.ar_valid && (!axi_req_i.aw_valid || !prio_w_q);
                axi_rsp_o.aw_ready = grant_w;
                axi_rsp_o.ar_ready = grant_r;
                if (grant_w) begin
                    state_d = WDATA;
                end else if (grant_r) begin
                    state_d = RDATA;
                end
            end
            WDATA: begin
                axi_rsp_o.w_ready = 1'b1;
                if (axi_req_i.w_valid && axi_req_i.w.last) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                axi_rsp_o.b_valid = 1'b1;
                axi_rsp_o.b.id    = id_q;
                axi_rsp_o.b.resp  = err_q;
                axi_rsp_o.b.user  = user_zero;
                if (axi_req_i.b_ready) begin
                    state_d = IDLE;
                end
            end
            RDATA: begin
                axi_rsp_o.r_valid = 1'b1;
                axi_rsp_o.r.id    = id_q;
                axi_rsp_o.r.data  = beat_ok ? mem_q[beat_idx] : '0;
                axi_rsp_o.r.resp  = beat_resp;
                axi_rsp_o.r.last  = read_last;
                axi_rsp_o.r.user  = user_zero;
                if (axi_req_i.r_ready && read_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transaction context: latched at AW/AR accept, advanced once per data beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_w_q  <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            txn_err_q <= 1'b0;
            err_q     <= RESP_OKAY;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_w) begin
                        prio_w_q  <= !prio_w_q;
                        id_q      <= axi_req_i.aw.id;
                        addr_q    <= axi_req_i.aw.addr;
                        len_q     <= axi_req_i.aw.len;
                        size_q    <= axi_req_i.aw.size;
                        burst_q   <= axi_req_i.aw.burst;
                        cnt_q     <= '0;
                        txn_err_q <= aw_illegal;
                        err_q     <= aw_illegal ? RESP_SLVERR : RESP_OKAY;
                    end else if (grant_r) begin
                        prio_w_q  <= !prio_w_q;
                        id_q      <= axi_req_i.ar.id;
                        addr_q    <= axi_req_i.ar.addr;
                        len_q     <= axi_req_i.ar.len;
                        size_q    <= axi_req_i.ar.size;
                        burst_q   <= axi_req_i.ar.burst;
                        cnt_q     <= '0;
                        txn_err_q <= ar_illegal;
                        err_q     <= ar_illegal ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                WDATA: begin
                    if (axi_req_i.w_valid) begin
                        addr_q <= next_addr;
                        cnt_q  <= cnt_q + 8'd1;
                        if (err_q == RESP_OKAY && beat_resp != RESP_OKAY) begin
                            err_q <= beat_resp;
                        end
                    end
                end
                RDATA: begin
                    if (axi_req_i.r_ready) begin
                        addr_q <= next_addr;
                        cnt_q  <= cnt_q + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Byte-masked array write. Illegal or out-of-window beats are dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWords; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == WDATA && axi_req_i.w_valid && beat_ok) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if (axi_req_i.w.strb[b]) begin
                    mem_q[beat_idx][b*8 +: 8] <= axi_req_i.w.data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_scratch_responder.sv
// tb_axi_scratch_responder
//   Drives AXI transactions into axi_scratch_responder. Expected B and R beats come
//   from a small reference model of the array and are queued at the time the
//   stimulus is issued. A negedge monitor pops and compares each beat on its
//   handshake.

module tb_axi_scratch_responder;
    import axi_scratch_pkg::*;

    localparam logic [63:0] BASE   = 64'h0000_0000_8000_1000;
    localparam int          NWORDS = 16;
    localparam logic [1:0]  INCR   = 2'b01;
    localparam logic [1:0]  FIXED  = 2'b00;
    localparam logic [1:0]  WRAP   = 2'b10;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    logic     clk = 1'b0;
    logic     rst;
    axi_req_t req;
    axi_rsp_t rsp;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_mem [NWORDS];
    b_exp_t      exp_b [$];
    r_exp_t      exp_r [$];
    b_exp_t      mon_b;
    r_exp_t      mon_r;

    always #5 clk = ~clk;

    axi_scratch_responder #(
        .AXI_ID_WIDTH   (8),
        .AXI_ADDR_WIDTH (64),
        .AXI_DATA_WIDTH (64),
        .AXI_USER_WIDTH (1),
        .BaseAddr       (BASE),
        .NumWords       (NWORDS),
        .axi_req_t      (axi_req_t),
        .axi_rsp_t      (axi_rsp_t)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .axi_req_i (req),
        .axi_rsp_o (rsp)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Monitor: every B/R handshake is compared against the head of its queue.
    always @(negedge clk) begin
        if (!rst && rsp.b_valid && req.b_ready) begin
            if (exp_b.size() == 0) begin
                checkOutput("B unexpected", 64'd1, 64'd0);
            end else begin
                mon_b = exp_b.pop_front();
                checkOutput("B id", 64'(rsp.b.id), 64'(mon_b.id));
                checkOutput("B resp", 64'(rsp.b.resp), 64'(mon_b.resp));
            end
        end
        if (!rst && rsp.r_valid && req.r_ready) begin
            if (exp_r.size() == 0) begin
                checkOutput("R unexpected", 64'd1, 64'd0);
            end else begin
                mon_r = exp_r.pop_front();
                checkOutput("R id", 64'(rsp.r.id), 64'(mon_r.id));
                checkOutput("R data", rsp.r.data, mon_r.data);
                checkOutput("R resp", 64'(rsp.r.resp), 64'(mon_r.resp));
                checkOutput("R last", 64'(rsp.r.last), 64'(mon_r.last));
            end
        end
    end

    function automatic logic [63:0] beat_addr(input logic [63:0] a, input int i,
                                              input logic [2:0] size, input logic [1:0] burst);
        return (burst == FIXED) ? a : a + 64'(i) * (64'd1 << size);
    endfunction

    function automatic logic model_in(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(NWORDS * 8));
    endfunction

    function automatic int model_idx(input logic [63:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    task automatic model_write(input logic [7:0] id, input logic [63:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [5:0] atop,
                               input logic [7:0] strb, input logic [63:0] data0);
        logic        illegal;
        logic [1:0]  err;
        logic [63:0] a;
        logic [63:0] d;
        illegal = (burst == WRAP) || (size > 3'd3) || (atop != 6'd0);
        err     = illegal ? 2'b10 : 2'b00;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, i, size, burst);
            d = data0 + 64'(i);
            if (!illegal) begin
                if (model_in(a)) begin
                    for (int b = 0; b < 8; b++) begin
                        if (strb[b]) model_mem[model_idx(a)][b*8 +: 8] = d[b*8 +: 8];
                    end
                end else if (err == 2'b00) begin
                    err = 2'b11;
                end
            end
        end
        exp_b.push_back('{id, err});
    endtask

    task automatic model_read(input logic [7:0] id, input logic [63:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst);
        logic        illegal;
        logic [63:0] a;
        illegal = (burst == WRAP) || (size > 3'd3);
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, i, size, burst);
            if (illegal) begin
                exp_r.push_back('{id, 64'd0, 2'b10, i == int'(len)});
            end else if (model_in(a)) begin
                exp_r.push_back('{id, model_mem[model_idx(a)], 2'b00, i == int'(len)});
            end else begin
                exp_r.push_back('{id, 64'd0, 2'b11, i == int'(len)});
            end
        end
    endtask

    task automatic set_aw(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [5:0] atop);
        req.aw       = '0;
        req.aw.id    = id;
        req.aw.addr  = addr;
        req.aw.len   = len;
        req.aw.size  = size;
        req.aw.burst = burst;
        req.aw.atop  = atop;
        req.aw_valid = 1'b1;
    endtask

    task automatic set_ar(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        req.ar       = '0;
        req.ar.id    = id;
        req.ar.addr  = addr;
        req.ar.len   = len;
        req.ar.size  = size;
        req.ar.burst = burst;
        req.ar_valid = 1'b1;
    endtask

    task automatic wait_aw();
        int n = 0;
        @(negedge clk);
        while (!rsp.aw_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp.aw_ready) checkOutput("aw_ready timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 req.aw_valid = 1'b0;
    endtask

    task automatic wait_ar();
        int n = 0;
        @(negedge clk);
        while (!rsp.ar_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp.ar_ready) checkOutput("ar_ready timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 req.ar_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        req.w      = '0;
        req.w.data = data;
        req.w.strb = strb;
        req.w.last = last;
        req.w_valid = 1'b1;
        @(negedge clk);
        while (!rsp.w_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp.w_ready) checkOutput("w_ready timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 req.w_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_b.size() != 0 || exp_r.size() != 0) begin
            checkOutput("drain timeout", 64'(exp_b.size() + exp_r.size()), 64'd0);
            exp_b.delete();
            exp_r.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic [5:0] atop, input logic [7:0] strb,
                               input logic [63:0] data0);
        model_write(id, addr, len, size, burst, atop, strb, data0);
        @(posedge clk);
        #1 set_aw(id, addr, len, size, burst, atop);
        wait_aw();
        for (int i = 0; i <= int'(len); i++) begin
            send_w(data0 + 64'(i), strb, i == int'(len));
        end
        wait_drain();
    endtask

    // stall_beat < 0: r_ready held high. Otherwise r_ready is pulsed once per beat
    // and held low for three cycles in front of beat stall_beat.
    task automatic read_burst(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input int stall_beat);
        model_read(id, addr, len, size, burst);
        @(posedge clk);
        #1;
        if (stall_beat >= 0) req.r_ready = 1'b0;
        set_ar(id, addr, len, size, burst);
        wait_ar();
        if (stall_beat >= 0) begin
            for (int b = 0; b <= int'(len); b++) begin
                if (b == stall_beat) begin
                    repeat (3) begin
                        @(negedge clk);
                        checkOutput("stall r_valid", 64'(rsp.r_valid), 64'd1);
                        checkOutput("stall data", rsp.r.data,
                                    exp_r.size() != 0 ? exp_r[0].data : 64'd0);
                        checkOutput("stall last", 64'(rsp.r.last),
                                    exp_r.size() != 0 ? 64'(exp_r[0].last) : 64'd0);
                        @(posedge clk);
                        #1;
                    end
                end
                req.r_ready = 1'b1;
                @(posedge clk);
                #1 req.r_ready = 1'b0;
            end
            req.r_ready = 1'b1;
        end
        wait_drain();
    endtask

    task automatic both_txn(input logic wfirst, input logic [7:0] wid, input logic [7:0] rid,
                            input int word, input logic [63:0] wdata);
        logic [63:0] addr;
        addr = BASE + 64'(word * 8);
        if (wfirst) begin
            model_write(wid, addr, 8'd0, 3'd3, INCR, 6'd0, 8'hFF, wdata);
            model_read(rid, addr, 8'd0, 3'd3, INCR);
        end else begin
            model_read(rid, addr, 8'd0, 3'd3, INCR);
            model_write(wid, addr, 8'd0, 3'd3, INCR, 6'd0, 8'hFF, wdata);
        end
        @(posedge clk);
        #1;
        set_aw(wid, addr, 8'd0, 3'd3, INCR, 6'd0);
        set_ar(rid, addr, 8'd0, 3'd3, INCR);
        @(negedge clk);
        checkOutput("grant aw_ready", 64'(rsp.aw_ready), 64'(wfirst));
        checkOutput("grant ar_ready", 64'(rsp.ar_ready), 64'(!wfirst));
        @(posedge clk);
        #1;
        if (wfirst) begin
            req.aw_valid = 1'b0;
            send_w(wdata, 8'hFF, 1'b1);
            wait_ar();
        end else begin
            req.ar_valid = 1'b0;
            wait_aw();
            send_w(wdata, 8'hFF, 1'b1);
        end
        wait_drain();
    endtask

    task automatic applyStimulus();
        // Reset state, with valids asserted to show readys stay low under reset.
        rst = 1'b1;
        req = '0;
        req.b_ready  = 1'b1;
        req.r_ready  = 1'b1;
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        req.w_valid  = 1'b1;
        for (int i = 0; i < NWORDS; i++) model_mem[i] = 64'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset aw_ready", 64'(rsp.aw_ready), 64'd0);
        checkOutput("reset ar_ready", 64'(rsp.ar_ready), 64'd0);
        checkOutput("reset w_ready", 64'(rsp.w_ready), 64'd0);
        checkOutput("reset b_valid", 64'(rsp.b_valid), 64'd0);
        checkOutput("reset r_valid", 64'(rsp.r_valid), 64'd0);
        checkOutput("reset b_resp", 64'(rsp.b.resp), 64'd0);
        checkOutput("reset r_data", rsp.r.data, 64'd0);
        req.aw_valid = 1'b0;
        req.ar_valid = 1'b0;
        req.w_valid  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] single write then read");
        write_burst(8'h11, BASE + 64'd8, 8'd0, 3'd3, INCR, 6'd0, 8'hFF, 64'hDEADBEEF_01234567);
        read_burst(8'h12, BASE + 64'd8, 8'd0, 3'd3, INCR, -1);

        $display("[TB] INCR burst with mid-burst stall");
        write_burst(8'h21, BASE, 8'd3, 3'd3, INCR, 6'd0, 8'hFF, 64'd1);
        read_burst(8'h22, BASE, 8'd3, 3'd3, INCR, 2);

        $display("[TB] window boundary and out-of-window reads");
        write_burst(8'h31, BASE + 64'd120, 8'd1, 3'd3, INCR, 6'd0, 8'hFF, 64'hA0);
        read_burst(8'h32, BASE + 64'd120, 8'd1, 3'd3, INCR, -1);
        read_burst(8'h33, BASE - 64'd8, 8'd0, 3'd3, INCR, -1);

        $display("[TB] FIXED burst");
        write_burst(8'h41, BASE + 64'd48, 8'd2, 3'd3, FIXED, 6'd0, 8'hFF, 64'h60);
        read_burst(8'h42, BASE + 64'd48, 8'd1, 3'd3, FIXED, -1);

        $display("[TB] illegal transactions and byte strobes");
        write_burst(8'h51, BASE + 64'd32, 8'd0, 3'd3, INCR, 6'd0, 8'hFF, 64'h4444);
        write_burst(8'h52, BASE + 64'd32, 8'd1, 3'd3, WRAP, 6'd0, 8'hFF, 64'h9999);
        write_burst(8'h53, BASE + 64'd32, 8'd0, 3'd3, INCR, 6'h20, 8'hFF, 64'h7777);
        read_burst(8'h54, BASE + 64'd32, 8'd0, 3'd3, INCR, -1);
        read_burst(8'h55, BASE + 64'd32, 8'd1, 3'd3, WRAP, -1);
        read_burst(8'h56, BASE + 64'd32, 8'd0, 3'd4, INCR, -1);
        write_burst(8'h57, BASE + 64'd24, 8'd0, 3'd3, INCR, 6'd0, 8'hFF, 64'h1111_2222_3333_4444);
        write_burst(8'h58, BASE + 64'd24, 8'd0, 3'd3, INCR, 6'd0, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD);
        read_burst(8'h59, BASE + 64'd24, 8'd0, 3'd3, INCR, -1);

        $display("[TB] reset during a read burst");
        write_burst(8'h61, BASE, 8'd3, 3'd3, INCR, 6'd0, 8'hFF, 64'h100);
        exp_r.push_back('{8'h66, model_mem[0], 2'b00, 1'b0});
        exp_r.push_back('{8'h66, model_mem[1], 2'b00, 1'b0});
        @(posedge clk);
        #1 set_ar(8'h66, BASE, 8'd3, 3'd3, INCR);
        wait_ar();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("r_valid after reset", 64'(rsp.r_valid), 64'd0);
        checkOutput("aborted read beats", 64'(exp_r.size()), 64'd0);
        exp_r.delete();
        for (int i = 0; i < NWORDS; i++) model_mem[i] = 64'd0;
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] AW/AR arbitration");
        both_txn(1'b1, 8'h71, 8'h72, 9, 64'hC0DE_0001);
        both_txn(1'b1, 8'h73, 8'h74, 9, 64'hC0DE_0002);
        write_burst(8'h75, BASE + 64'd80, 8'd0, 3'd3, INCR, 6'd0, 8'hFF, 64'hBEEF);
        both_txn(1'b0, 8'h76, 8'h77, 9, 64'hC0DE_0003);

        $display("[TB] readback of words cleared by reset");
        read_burst(8'h81, BASE, 8'd3, 3'd3, INCR, -1);
        read_burst(8'h82, BASE + 64'd72, 8'd0, 3'd3, INCR, -1);
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
